// File: rtl/systolic_feed_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module  : feed_sched_pkg
// Brief   : Shared widths and FSM state encoding for the systolic feed scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package feed_sched_pkg;

   localparam int N_ROWS  = 8;
   localparam int DIAG_W  = N_ROWS * 8;
   localparam int CYCLE_W = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_STEP  = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_feed_scheduler_if.sv
//------------------------------------------------------------------------------
// Module  : systolic_feed_scheduler_if
// Brief   : Control, extractor and array-feed signals of the feed scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface systolic_feed_scheduler_if;
   import feed_sched_pkg::*;

   logic               go;
   logic               busy;
   logic               done;
   logic               error;
   logic               ext_start;
   logic [CYCLE_W-1:0] ext_cycle;
   logic               a_valid;
   logic [DIAG_W-1:0]  a_flat;
   logic               b_valid;
   logic [DIAG_W-1:0]  b_flat;
   logic               arr_ready;
   logic               arr_clear;
   logic [DIAG_W-1:0]  arr_a;
   logic [DIAG_W-1:0]  arr_b;
   logic               arr_step;

   // Scheduler side
   modport master (
      input  go, a_valid, a_flat, b_valid, b_flat, arr_ready,
      output busy, done, error, ext_start, ext_cycle,
             arr_clear, arr_a, arr_b, arr_step
   );

   // Control / extractor / array side
   modport slave (
      output go, a_valid, a_flat, b_valid, b_flat, arr_ready,
      input  busy, done, error, ext_start, ext_cycle,
             arr_clear, arr_a, arr_b, arr_step
   );

endinterface

`default_nettype wire

// File: rtl/systolic_feed_scheduler_sat_counter.sv
//------------------------------------------------------------------------------
// Module  : sat_counter
// Brief   : Clearable, enabled up-counter that saturates at MAX and flags it.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_clr,
   input  wire logic i_en,
   output logic      o_term
);

   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != c_MAX)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_term = (r_count == c_MAX);

endmodule

`default_nettype wire

// File: rtl/systolic_feed_scheduler.sv
//------------------------------------------------------------------------------
// Module  : systolic_feed_scheduler
// Brief   : Sequences one skewed operand feed of an 8x8 systolic array.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_feed_scheduler
   import feed_sched_pkg::*;
#(
   parameter int NUM_CYCLES   = 15,
   parameter int DRAIN_CYCLES = 8,
   parameter int TIMEOUT      = 1024
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   systolic_feed_scheduler_if.master  io_feed
);

   localparam logic [CYCLE_W-1:0] c_LAST_K    = CYCLE_W'(NUM_CYCLES - 1);
   localparam int                 c_DRAIN_MAX = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

   state_t              r_state;
   state_t              w_next;
   logic [CYCLE_W-1:0]  r_k;
   logic                r_got_a;
   logic                r_got_b;
   logic                r_error;
   logic [DIAG_W-1:0]   r_arr_a;
   logic [DIAG_W-1:0]   r_arr_b;
   logic                w_both;
   logic                w_last;
   logic                w_wd_term;
   logic                w_dr_term;
   logic                w_busy;
   logic                w_done;
   logic                w_ext_start;
   logic                w_arr_clear;
   logic                w_arr_step;

   // Flags as they will stand after this edge, so a same-cycle pair advances at once
   assign w_both = (r_got_a | io_feed.a_valid) & (r_got_b | io_feed.b_valid);
   assign w_last = (r_k == c_LAST_K);

   sat_counter #(.WIDTH(16), .MAX(TIMEOUT - 1)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (r_state == S_ISSUE),
      .i_en   (r_state == S_WAIT),
      .o_term (w_wd_term)
   );

   sat_counter #(.WIDTH(8), .MAX(c_DRAIN_MAX)) u_drain_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (r_state != S_DRAIN),
      .i_en   ((r_state == S_DRAIN) && io_feed.arr_ready),
      .o_term (w_dr_term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_ext_start = 1'b0;
      w_arr_clear = 1'b0;
      w_arr_step  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_feed.go) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            w_busy      = 1'b1;
            w_arr_clear = 1'b1;
            w_next      = S_ISSUE;
         end
         S_ISSUE: begin
            w_busy      = 1'b1;
            w_ext_start = 1'b1;
            w_next      = S_WAIT;
         end
         S_WAIT: begin
            w_busy = 1'b1;
            if (w_both) begin
               w_next = S_STEP;
            end else if (w_wd_term) begin
               w_next = S_ERR;
            end
         end
         S_STEP: begin
            w_busy     = 1'b1;
            w_arr_step = io_feed.arr_ready;
            if (io_feed.arr_ready) begin
               if (w_last) begin
                  w_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
               end else begin
                  w_next = S_ISSUE;
               end
            end
         end
         S_DRAIN: begin
            w_busy     = 1'b1;
            w_arr_step = io_feed.arr_ready;
            if (io_feed.arr_ready && w_dr_term) w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k     <= '0;
         r_got_a <= 1'b0;
         r_got_b <= 1'b0;
         r_error <= 1'b0;
         r_arr_a <= '0;
         r_arr_b <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_feed.go) begin
                  r_k     <= '0;
                  r_error <= 1'b0;
               end
            end
            S_ISSUE: begin
               r_got_a <= 1'b0;
               r_got_b <= 1'b0;
            end
            S_WAIT: begin
               if (io_feed.a_valid) begin
                  r_got_a <= 1'b1;
                  r_arr_a <= io_feed.a_flat;
               end
               if (io_feed.b_valid) begin
                  r_got_b <= 1'b1;
                  r_arr_b <= io_feed.b_flat;
               end
               if (!w_both && w_wd_term) r_error <= 1'b1;
            end
            S_STEP: begin
               if (io_feed.arr_ready) begin
                  if (w_last) begin
                     r_arr_a <= '0;
                     r_arr_b <= '0;
                  end else begin
                     r_k <= r_k + CYCLE_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign io_feed.busy      = w_busy;
   assign io_feed.done      = w_done;
   assign io_feed.error     = r_error;
   assign io_feed.ext_start = w_ext_start;
   assign io_feed.ext_cycle = r_k;
   assign io_feed.arr_clear = w_arr_clear;
   assign io_feed.arr_a     = r_arr_a;
   assign io_feed.arr_b     = r_arr_b;
   assign io_feed.arr_step  = w_arr_step;

endmodule

`default_nettype wire

// File: tb/tb_systolic_feed_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_systolic_feed_scheduler
// Brief   : Directed self-checking bench for systolic_feed_scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_feed_scheduler;
   import feed_sched_pkg::*;

   localparam int c_NUM   = 15;
   localparam int c_DRAIN = 8;
   localparam int c_TO    = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_steps  = 0;
   int   n_starts = 0;
   int   n_done   = 0;

   systolic_feed_scheduler_if u_if ();

   systolic_feed_scheduler #(
      .NUM_CYCLES   (c_NUM),
      .DRAIN_CYCLES (c_DRAIN),
      .TIMEOUT      (c_TO)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .io_feed (u_if)
   );

   always #5 clk = ~clk;

   // Event tallies sampled mid-cycle
   always @(negedge clk) begin
      if (u_if.arr_step)  n_steps++;
      if (u_if.ext_start) n_starts++;
      if (u_if.done)      n_done++;
   end

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_feed();
      u_if.go = 1'b1;
      step_clk();
      u_if.go = 1'b0;
      chk("clear_busy", u_if.busy, 1);
      chk("clear_pulse", u_if.arr_clear, 1);
      chk("clear_error", u_if.error, 0);
      chk("clear_nostart", u_if.ext_start, 0);
      step_clk();
      chk("issue_noclear", u_if.arr_clear, 0);
   endtask

   task automatic do_diag(input int k, input int la, input int lb, input int lpre,
                          input int stall_n, input bit spur, input bit bdist);
      logic [63:0] ea;
      logic [63:0] eb;
      int          m;
      ea = {8{8'(k)}};
      eb = bdist ? {8{8'(8'h80 + k)}} : ea;
      chk("issue_start", u_if.ext_start, 1);
      chk("issue_cycle", u_if.ext_cycle, k);
      chk("issue_busy", u_if.busy, 1);
      m = (la > lb) ? la : lb;
      for (int c = 1; c <= m; c++) begin
         step_clk();
         chk("wait_nostart", u_if.ext_start, 0);
         chk("wait_nostep", u_if.arr_step, 0);
         u_if.a_valid = (c == la) || (c == lpre);
         u_if.a_flat  = (c == lpre) ? 64'hDEAD_BEEF_DEAD_BEEF : ea;
         u_if.b_valid = (c == lb);
         u_if.b_flat  = eb;
      end
      step_clk();
      u_if.a_valid = 1'b0;
      u_if.b_valid = 1'b0;
      if (stall_n > 0) begin
         u_if.arr_ready = 1'b0;
         for (int s = 0; s < stall_n; s++) begin
            #1;
            chk("stall_nostep", u_if.arr_step, 0);
            chk("stall_a", u_if.arr_a, ea);
            chk("stall_b", u_if.arr_b, eb);
            chk("stall_nostart", u_if.ext_start, 0);
            step_clk();
         end
         u_if.arr_ready = 1'b1;
      end
      #1;
      chk("step_strobe", u_if.arr_step, 1);
      chk("step_a", u_if.arr_a, ea);
      chk("step_b", u_if.arr_b, eb);
      if (spur) begin
         u_if.go      = 1'b1;
         u_if.a_valid = 1'b1;
         u_if.a_flat  = 64'h0BAD_0BAD_0BAD_0BAD;
      end
      step_clk();
      u_if.go      = 1'b0;
      u_if.a_valid = 1'b0;
      if (spur && (k != c_NUM - 1)) begin
         chk("spur_hold_a", u_if.arr_a, ea);
         chk("spur_noclear", u_if.arr_clear, 0);
      end
   endtask

   task automatic do_drain(input int stall_at, input int stall_n);
      int d;
      int cyc;
      d   = 0;
      cyc = 0;
      chk("drain_a_zero", u_if.arr_a, 0);
      chk("drain_b_zero", u_if.arr_b, 0);
      while ((d < c_DRAIN) && (cyc < 40)) begin
         u_if.arr_ready = !((cyc >= stall_at) && (cyc < stall_at + stall_n));
         #1;
         chk("drain_strobe", u_if.arr_step, u_if.arr_ready);
         chk("drain_a", u_if.arr_a, 0);
         chk("drain_busy", u_if.busy, 1);
         chk("drain_nodone", u_if.done, 0);
         if (u_if.arr_ready) d++;
         cyc++;
         step_clk();
      end
      u_if.arr_ready = 1'b1;
      chk("drain_count", d, c_DRAIN);
      chk("done_pulse", u_if.done, 1);
      chk("done_busy", u_if.busy, 0);
      chk("done_error", u_if.error, 0);
      step_clk();
      chk("done_once", u_if.done, 0);
   endtask

   // mode: 0 nominal, 1 skewed valids, 2 backpressure, 3 spurious inputs
   task automatic run_feed(input int mode);
      int s0, e0, d0;
      int la, lb, lpre, st;
      bit sp, bd;
      s0 = n_steps;
      e0 = n_starts;
      d0 = n_done;
      start_feed();
      for (int k = 0; k < c_NUM; k++) begin
         la = 5; lb = 5; lpre = 0; st = 0; sp = 1'b0; bd = 1'b0;
         if (mode == 1) begin
            bd = 1'b1;
            case (k % 3)
               0:       begin lpre = 2; la = 3; lb = 9; end
               1:       begin la = 4; lb = 4; end
               default: begin la = 6; lb = 2; end
            endcase
         end
         if ((mode == 2) && (k == 7)) st = 4;
         if ((mode == 3) && ((k == 2) || (k == 6))) sp = 1'b1;
         do_diag(k, la, lb, lpre, st, sp, bd);
      end
      if (mode == 2) do_drain(3, 2);
      else           do_drain(0, 0);
      chk("feed_steps", n_steps - s0, c_NUM + c_DRAIN);
      chk("feed_starts", n_starts - e0, c_NUM);
      chk("feed_dones", n_done - d0, 1);
   endtask

   initial begin
      int d0;
      u_if.go        = 1'b0;
      u_if.a_valid   = 1'b0;
      u_if.b_valid   = 1'b0;
      u_if.a_flat    = '0;
      u_if.b_flat    = '0;
      u_if.arr_ready = 1'b1;
      rst            = 1'b1;
      #1;
      chk("rst_busy", u_if.busy, 0);
      chk("rst_done", u_if.done, 0);
      chk("rst_error", u_if.error, 0);
      chk("rst_ext_start", u_if.ext_start, 0);
      chk("rst_ext_cycle", u_if.ext_cycle, 0);
      chk("rst_clear", u_if.arr_clear, 0);
      chk("rst_arr_a", u_if.arr_a, 0);
      chk("rst_arr_b", u_if.arr_b, 0);
      chk("rst_step", u_if.arr_step, 0);
      step_clk();
      step_clk();
      rst = 1'b0;
      step_clk();
      chk("idle_busy", u_if.busy, 0);

      run_feed(0);
      run_feed(1);
      run_feed(2);

      u_if.a_valid = 1'b1;
      u_if.a_flat  = 64'h1234_5678_9ABC_DEF0;
      step_clk();
      step_clk();
      u_if.a_valid = 1'b0;
      chk("idle_valid_ignored", u_if.arr_a, 0);
      chk("idle_valid_busy", u_if.busy, 0);
      run_feed(3);

      // Watchdog: b never arrives at k=3
      d0 = n_done;
      start_feed();
      for (int k = 0; k < 3; k++) do_diag(k, 5, 5, 0, 0, 1'b0, 1'b0);
      chk("to_issue_cycle", u_if.ext_cycle, 3);
      for (int w = 1; w <= c_TO; w++) begin
         step_clk();
         chk("to_wait_busy", u_if.busy, 1);
         chk("to_wait_error", u_if.error, 0);
         u_if.a_valid = (w == 2);
         u_if.a_flat  = {8{8'h03}};
      end
      step_clk();
      u_if.a_valid = 1'b0;
      chk("to_error_set", u_if.error, 1);
      chk("to_busy_low", u_if.busy, 0);
      chk("to_no_done", u_if.done, 0);
      step_clk();
      chk("to_error_sticky", u_if.error, 1);
      chk("to_idle_nostart", u_if.ext_start, 0);
      step_clk();
      chk("to_done_count", n_done - d0, 0);
      run_feed(0);

      // Asynchronous reset in the middle of WAIT at k=5
      start_feed();
      for (int k = 0; k < 5; k++) do_diag(k, 5, 5, 0, 0, 1'b0, 1'b0);
      chk("rs_issue_cycle", u_if.ext_cycle, 5);
      step_clk();
      step_clk();
      d0 = n_done;
      #2;
      rst = 1'b1;
      #1;
      chk("rs_busy", u_if.busy, 0);
      chk("rs_ext_cycle", u_if.ext_cycle, 0);
      chk("rs_ext_start", u_if.ext_start, 0);
      chk("rs_arr_a", u_if.arr_a, 0);
      chk("rs_arr_b", u_if.arr_b, 0);
      chk("rs_step", u_if.arr_step, 0);
      chk("rs_clear", u_if.arr_clear, 0);
      step_clk();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_clk();
         chk("rs_idle_nostart", u_if.ext_start, 0);
         chk("rs_idle_busy", u_if.busy, 0);
      end
      chk("rs_no_done", n_done - d0, 0);
      run_feed(0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule

`default_nettype wire
